// File: rtl/mod_redu_pipe_if.sv
// mod_redu_pipe_if: handshake bundle for the Barrett reducer (input beat stream + result stream).
// Latency: none, wires only.
// Backpressure: in_ready/out_ready travel against the data direction.
interface mod_redu_pipe_if #(
  parameter int QW    = 12,
  parameter int LANES = 1,
  parameter int TAG_W = 8
);
  localparam int DW = 2 * QW;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*QW-1:0]   out_data;
  logic [TAG_W-1:0]      out_tag;
  logic [LANES-1:0]      out_ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_ovf
  );

  // Reducer side
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_ovf
  );
endinterface

// File: rtl/mod_redu_pipe.sv
// mod_redu_pipe: pipelined Barrett reducer, LANES x (2*QW)-bit products -> canonical residues mod Q.
// Latency: 3 cycles accept-to-out_valid; one beat per cycle sustained.
// Backpressure: all stages stall together when S3 is full and out_ready=0; in_ready follows that stall.
// Build option MOD_RANGE_CHK_EN: flag lanes whose operand exceeds (Q-1)^2 on out_ovf (else out_ovf=0).
module mod_redu_pipe #(
  parameter int Q     = 3329,
  parameter int QW    = 12,
  parameter int LANES = 1,
  parameter int TAG_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mod_redu_pipe_if.slave bus
);

  localparam int DW = 2 * QW;
  // Products are formed at twice the operand width so x*M and qhat*Q never overflow.
  localparam int PW = 2 * DW;
  localparam longint unsigned BARRETT_M = (64'd1 << DW) / 64'(Q);
  localparam logic [PW-1:0]   M_EXT     = PW'(BARRETT_M);
  localparam logic [QW+1:0]   Q1        = (QW+2)'(Q);
  localparam logic [QW+1:0]   Q2        = (QW+2)'(2 * Q);
`ifdef MOD_RANGE_CHK_EN
  localparam longint unsigned QM1       = 64'(Q) - 64'd1;
  localparam logic [DW-1:0]   MAX_IN    = DW'(QM1 * QM1);
`endif

  logic                        adv;

  logic                        s1_vld_q, s2_vld_q, s3_vld_q;
  logic [LANES-1:0][DW-1:0]    s1_x_d, s1_x_q;
  logic [LANES-1:0][QW:0]      s1_qh_d, s1_qh_q;
  logic [LANES-1:0][QW+1:0]    s2_r_d, s2_r_q;
  logic [LANES-1:0][QW-1:0]    s3_res_d, s3_res_q;
  logic [LANES-1:0]            s1_ovf_d, s1_ovf_q, s2_ovf_q, s3_ovf_q;
  logic [TAG_W-1:0]            s1_tag_q, s2_tag_q, s3_tag_q;

  // Only a full S3 facing a stalled consumer can block; reset always reads as ready.
  assign adv          = !(s3_vld_q && !bus.out_ready);
  assign bus.in_ready = adv || rst;

  assign bus.out_valid = s3_vld_q;
  assign bus.out_data  = s3_res_q;
  assign bus.out_tag   = s3_tag_q;
  assign bus.out_ovf   = s3_ovf_q;

  // S1: quotient estimate qhat = (x*M) >> DW, plus the optional range flag.
  always_comb begin
    s1_x_d   = '0;
    s1_qh_d  = '0;
    s1_ovf_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_x_d[i]  = bus.in_data[i*DW +: DW];
      s1_qh_d[i] = (QW+1)'((PW'(bus.in_data[i*DW +: DW]) * M_EXT) >> DW);
`ifdef MOD_RANGE_CHK_EN
      s1_ovf_d[i] = (bus.in_data[i*DW +: DW] > MAX_IN);
`else
      s1_ovf_d[i] = 1'b0;
`endif
    end
  end

  // S2: remainder r = x - qhat*Q; only the low QW+2 bits matter since r < 3Q.
  always_comb begin
    s2_r_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_r_d[i] = (QW+2)'(PW'(s1_x_q[i]) - PW'(s1_qh_q[i]) * PW'(Q));
    end
  end

  // S3: at most two conditional subtractions bring r into [0, Q).
  always_comb begin
    s3_res_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_r_q[i] >= Q2) begin
        s3_res_d[i] = QW'(s2_r_q[i] - Q2);
      end else if (s2_r_q[i] >= Q1) begin
        s3_res_d[i] = QW'(s2_r_q[i] - Q1);
      end else begin
        s3_res_d[i] = QW'(s2_r_q[i]);
      end
    end
  end

  // Pipeline registers: shift all stages together on adv, hold everything otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_qh_q  <= '0;
      s2_r_q   <= '0;
      s3_res_q <= '0;
      s1_ovf_q <= '0;
      s2_ovf_q <= '0;
      s3_ovf_q <= '0;
      s1_tag_q <= '0;
      s2_tag_q <= '0;
      s3_tag_q <= '0;
    end else if (adv) begin
      s1_vld_q <= bus.in_valid;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      s1_x_q   <= s1_x_d;
      s1_qh_q  <= s1_qh_d;
      s2_r_q   <= s2_r_d;
      s3_res_q <= s3_res_d;
      s1_ovf_q <= s1_ovf_d;
      s2_ovf_q <= s1_ovf_q;
      s3_ovf_q <= s2_ovf_q;
      s1_tag_q <= bus.in_tag;
      s2_tag_q <= s1_tag_q;
      s3_tag_q <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_mod_redu_pipe.sv
// tb_mod_redu_pipe: bench for the Barrett reducer, Kyber single-lane and Dilithium 4-lane builds.
// Latency: n/a.
// Backpressure: bench drives out_ready patterns, including long stalls and random toggling.
`timescale 1ns/1ps
module tb_mod_redu_pipe;

  localparam int KQ  = 3329;
  localparam int KQW = 12;
  localparam int DQ  = 8380417;
  localparam int DQW = 23;
  localparam int DL  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_redu_pipe_if #(.QW(KQW), .LANES(1),  .TAG_W(8)) kif ();
  mod_redu_pipe_if #(.QW(DQW), .LANES(DL), .TAG_W(8)) dif ();

  mod_redu_pipe #(.Q(KQ), .QW(KQW), .LANES(1), .TAG_W(8)) dut_k (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  mod_redu_pipe #(.Q(DQ), .QW(DQW), .LANES(DL), .TAG_W(8)) dut_d (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct { logic [11:0] res; logic [7:0] tag; logic ovf; } exp_t;
  typedef struct { logic [23:0] x; logic [7:0] tag; logic [11:0] res; } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic kovf(input logic [23:0] x);
`ifdef MOD_RANGE_CHK_EN
    return x > 24'd11075584;
`else
    return (x != x);
`endif
  endfunction

  // One cycle on the Kyber instance: drive after the edge, then note whether the beat will be taken.
  task automatic kstep(input logic v, input logic [23:0] x, input logic [7:0] tag,
                       input logic [11:0] res, input logic ordy, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    kif.in_valid  = v;
    kif.in_data   = x;
    kif.in_tag    = tag;
    kif.out_ready = ordy;
    #1;
    acc = v && kif.in_ready && !rst;
    if (acc) begin
      e.res = res;
      e.tag = tag;
      e.ovf = kovf(x);
      sbq.push_back(e);
    end
  endtask

  task automatic kdrain();
    logic a;
    int   n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      kstep(1'b0, 24'd0, 8'd0, 12'd0, 1'b1, a);
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Scoreboard: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && kif.out_valid && kif.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data %0d tag %0d, expected no beat", kif.out_data, kif.out_tag);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_data", kif.out_data, mon_e.res);
        chk("out_tag", kif.out_tag, mon_e.tag);
        chk("out_ovf", kif.out_ovf, mon_e.ovf);
        chk("res_lt_q", kif.out_data < 12'(KQ), 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t            tv[4];
  logic            acc;
  logic            ovh[12];
  logic            vh[12];
  logic [23:0]     hx[6];
  logic [23:0]     rx;
  logic [11:0]     held;
  logic [63:0]     dv[4];
  int              nb;
  int              sent;
  int              cyc;
  int              sel;
  int              n;

  initial begin
    tv[0] = '{x: 24'd0,        tag: 8'd0, res: 12'd0};
    tv[1] = '{x: 24'd3329,     tag: 8'd1, res: 12'd0};
    tv[2] = '{x: 24'd11075584, tag: 8'd2, res: 12'd1};
    tv[3] = '{x: 24'd16777215, tag: 8'd3, res: 12'd2384};

    rst = 1'b1;
    kif.in_valid = 1'b0; kif.in_data = '0; kif.in_tag = '0; kif.out_ready = 1'b1;
    dif.in_valid = 1'b0; dif.in_data = '0; dif.in_tag = '0; dif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", kif.out_valid, 0);
    chk("rst_out_data", kif.out_data, 0);
    chk("rst_out_tag", kif.out_tag, 0);
    chk("rst_out_ovf", kif.out_ovf, 0);
    chk("rst_in_ready", kif.in_ready, 1);
    chk("rst_d_out_valid", dif.out_valid, 0);
    chk("rst_d_out_data", dif.out_data, 0);

    // Table vectors back to back: first result 3 cycles after the first accept, then every cycle.
    for (int i = 0; i < 10; i++) begin
      if (i < 4) kstep(1'b1, tv[i].x, tv[i].tag, tv[i].res, 1'b1, acc);
      else       kstep(1'b0, 24'd0, 8'd0, 12'd0, 1'b1, acc);
      ovh[i] = kif.out_valid;
      if (i < 4) chk("tbl_accept", acc, 1);
    end
    for (int i = 0; i < 10; i++) chk("tbl_vld_pattern", ovh[i], (i >= 3 && i <= 6));
    kdrain();

    // Stall: two beats in flight, then out_ready low for 5 cycles with in_valid held high.
    hx[0] = 24'd123456; hx[1] = 24'd16777215; hx[2] = 24'd3328;
    hx[3] = 24'd6658;   hx[4] = 24'd9999999;  hx[5] = 24'd1;
    nb = 0;
    for (int i = 0; i < 14; i++) begin
      if (nb < 6) kstep(1'b1, hx[nb], 8'(16 + nb), 12'(hx[nb] % KQ), !(i >= 2 && i <= 6), acc);
      else        kstep(1'b0, 24'd0, 8'd0, 12'd0, 1'b1, acc);
      if (acc) nb++;
      if (i == 3) begin
        held = kif.out_data;
        chk("stall_first", held, 12'(hx[0] % KQ));
      end
      if (i >= 3 && i <= 6) begin
        chk("stall_out_valid", kif.out_valid, 1);
        chk("stall_in_ready", kif.in_ready, 0);
        chk("stall_hold_data", kif.out_data, held);
        chk("stall_hold_tag", kif.out_tag, 16);
      end
    end
    chk("stall_all_sent", nb, 6);
    kdrain();

    // Dilithium, 4 lanes.
    dv[0] = 64'(DQ - 1) * 64'(DQ - 1);
    dv[1] = 64'(DQ);
    dv[2] = 64'(DQ - 1);
    dv[3] = 64'h3FFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1;
    dif.in_data  = {dv[3][45:0], dv[2][45:0], dv[1][45:0], dv[0][45:0]};
    dif.in_tag   = 8'hA5;
    #1;
    chk("d_in_ready", dif.in_ready, 1);
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    n = 0;
    while (!dif.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("d_latency", n, 2);
    for (int l = 0; l < DL; l++) chk("d_lane", dif.out_data[l*DQW +: DQW], dv[l] % 64'(DQ));
    chk("d_lane0_const", dif.out_data[0 +: DQW], 1);
    chk("d_tag", dif.out_tag, 8'hA5);
`ifdef MOD_RANGE_CHK_EN
    chk("d_ovf", dif.out_ovf, 4'b1000);
`else
    chk("d_ovf", dif.out_ovf, 4'b0000);
`endif

    // Reset with three beats in flight: everything is discarded.
    for (int i = 0; i < 3; i++) kstep(1'b1, 24'(1000 * (i + 1)), 8'(40 + i), 12'((1000 * (i + 1)) % KQ), 1'b1, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    kif.in_valid = 1'b1;
    kif.out_ready = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_in_ready", kif.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    kif.in_valid = 1'b0;
    kif.out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", kif.out_valid, 0);
    chk("midrst_out_data", kif.out_data, 0);
    chk("midrst_out_tag", kif.out_tag, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) kstep(1'b1, 24'd12345, 8'h5A, 12'(12345 % KQ), 1'b1, acc);
      else        kstep(1'b0, 24'd0, 8'd0, 12'd0, 1'b1, acc);
      ovh[i] = kif.out_valid;
    end
    for (int i = 0; i < 7; i++) chk("postrst_vld_pattern", ovh[i], (i == 3));
    kdrain();

    // Bubbles: alternate in_valid, result validity follows 3 cycles later.
    for (int i = 0; i < 12; i++) begin
      vh[i] = (i < 8) && (i % 2 == 0);
      rx = 24'($urandom);
      kstep(vh[i], rx, 8'(80 + i), 12'(rx % KQ), 1'b1, acc);
      ovh[i] = kif.out_valid;
    end
    for (int i = 3; i < 12; i++) chk("bubble_vld", ovh[i], vh[i - 3]);
    kdrain();

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    rx   = 24'($urandom);
    while (sent < 10000 && cyc < 60000) begin
      kstep($urandom_range(0, 3) != 0, rx, 8'(sent), 12'(rx % KQ), $urandom_range(0, 3) != 0, acc);
      cyc++;
      if (acc) begin
        sent++;
        sel = $urandom_range(0, 15);
        if (sel == 0)      rx = 24'hFFFFFF;
        else if (sel == 1) rx = 24'd0;
        else if (sel == 2) rx = 24'd11075585;
        else               rx = 24'($urandom);
      end
    end
    chk("rand_sent", sent, 10000);
    kdrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
